ro_meas_sequencer: RTL and testbench

Measurement sequencer for the ring-oscillator temperature sensor. Accepts one-byte commands from the UART receiver, powers up the selected ring oscillator, lets it settle, opens a fixed-length counting gate on the external RO edge counter, then ships the latched count back through the UART transmitter as a 3-byte frame. It sits between the UART RX/TX blocks and the RO/counter datapath in the top level.

---
 rtl/ro_meas_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_ro_meas_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_meas_sequencer.sv
// Ring-oscillator measurement sequencer: command in, settle/gate/hold timing, 3-byte result frame out.
// Optional build macro ROSEQ_AUTO_EN adds an idle-timeout self-trigger that alternates RO0/RO1.
module ro_meas_sequencer #(
  parameter int CNT_W  = 16,
  parameter int SETTLE = 64,
  parameter int GATE   = 1024,
  parameter int HOLD   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_data,
  input  logic [CNT_W-1:0] ro_count,
  input  logic             tx_ready,
  output logic [1:0]       ro_en,
  output logic             cnt_clr,
  output logic             cnt_gate,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             cmd_drop
);

  localparam int MAX_SG = (SETTLE > GATE) ? SETTLE : GATE;
  localparam int MAX_D  = (MAX_SG > HOLD) ? MAX_SG : HOLD;
  localparam int TW     = $clog2(MAX_D + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GATE   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SEND   = 3'd4
  } state_t;

  state_t           state_r;
  logic [TW-1:0]    timer_r;
  logic             osc_r;
  logic [CNT_W-1:0] result_r;
  logic [1:0]       byte_idx_r;
  logic             start_s;
  logic             start_osc_s;
  logic             drop_s;
`ifdef ROSEQ_AUTO_EN
  logic [11:0]      idle_cnt_r;
  logic             auto_osc_r;
  logic             auto_fire_s;
`endif

  function automatic logic [1:0] onehot(input logic osc);
    return osc ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] header(input logic osc);
    return {7'b1010000, osc};
  endfunction

  // Command decode: start request, oscillator choice and discard pulse
  always_comb begin
    start_s     = 1'b0;
    start_osc_s = cmd_data[0];
    drop_s      = 1'b0;
`ifdef ROSEQ_AUTO_EN
    auto_fire_s = 1'b0;
`endif
    if (state_r == ST_IDLE) begin
      if (cmd_valid) begin
        if (en && (cmd_data[7:1] == 7'd0)) begin
          start_s = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
`ifdef ROSEQ_AUTO_EN
        // an explicit command always pre-empts the idle timeout
        if (en && (idle_cnt_r == 12'd4095)) begin
          start_s     = 1'b1;
          start_osc_s = auto_osc_r;
          auto_fire_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
`else
        start_s = 1'b0;
`endif
      end
    end else begin
      drop_s = cmd_valid;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      timer_r    <= '0;
      osc_r      <= 1'b0;
      result_r   <= '0;
      byte_idx_r <= 2'd0;
      ro_en      <= 2'b00;
      cnt_clr    <= 1'b0;
      cnt_gate   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      cmd_drop   <= 1'b0;
`ifdef ROSEQ_AUTO_EN
      idle_cnt_r <= 12'd0;
      auto_osc_r <= 1'b0;
`endif
    end else if ((state_r != ST_IDLE) && !en) begin
      // abort: everything back to reset values, partial frame discarded
      state_r    <= ST_IDLE;
      timer_r    <= '0;
      byte_idx_r <= 2'd0;
      ro_en      <= 2'b00;
      cnt_clr    <= 1'b0;
      cnt_gate   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      cmd_drop   <= 1'b0;
`ifdef ROSEQ_AUTO_EN
      idle_cnt_r <= 12'd0;
`endif
    end else begin
      cmd_drop <= drop_s;
      cnt_clr  <= 1'b0;
`ifdef ROSEQ_AUTO_EN
      idle_cnt_r <= 12'd0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r <= ST_SETTLE;
            osc_r   <= start_osc_s;
            ro_en   <= onehot(start_osc_s);
            cnt_clr <= 1'b1;
            busy    <= 1'b1;
            timer_r <= TW'(SETTLE - 1);
`ifdef ROSEQ_AUTO_EN
            if (auto_fire_s) begin
              auto_osc_r <= ~auto_osc_r;
            end
`endif
          end else begin
            state_r <= ST_IDLE;
`ifdef ROSEQ_AUTO_EN
            if (en && !cmd_valid) begin
              idle_cnt_r <= idle_cnt_r + 12'd1;
            end
`endif
          end
        end
        ST_SETTLE: begin
          if (timer_r == '0) begin
            state_r  <= ST_GATE;
            cnt_gate <= 1'b1;
            timer_r  <= TW'(GATE - 1);
          end else begin
            timer_r <= timer_r - TW'(1);
          end
        end
        ST_GATE: begin
          if (timer_r == '0) begin
            state_r  <= ST_HOLD;
            cnt_gate <= 1'b0;
            ro_en    <= 2'b00;
            timer_r  <= TW'(HOLD - 1);
          end else begin
            timer_r <= timer_r - TW'(1);
          end
        end
        ST_HOLD: begin
          if (timer_r == '0) begin
            state_r    <= ST_SEND;
            result_r   <= ro_count;
            tx_data    <= header(osc_r);
            tx_valid   <= 1'b1;
            byte_idx_r <= 2'd0;
          end else begin
            timer_r <= timer_r - TW'(1);
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            case (byte_idx_r)
              2'd0: begin
                tx_data    <= result_r[15:8];
                byte_idx_r <= 2'd1;
              end
              2'd1: begin
                tx_data    <= result_r[7:0];
                byte_idx_r <= 2'd2;
              end
              default: begin
                state_r    <= ST_IDLE;
                tx_valid   <= 1'b0;
                tx_data    <= 8'h00;
                busy       <= 1'b0;
                byte_idx_r <= 2'd0;
              end
            endcase
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ro_en    <= 2'b00;
          cnt_gate <= 1'b0;
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Self-checking bench for ro_meas_sequencer: command vector table, frame scoreboard, corner sequences.
module tb_ro_meas_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic [15:0] ro_count;
  logic        tx_ready;
  logic [1:0]  ro_en;
  logic        cnt_clr;
  logic        cnt_gate;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic        cmd_drop;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  ro_meas_sequencer #(.CNT_W(16), .SETTLE(4), .GATE(16), .HOLD(2)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .ro_count(ro_count), .tx_ready(tx_ready), .ro_en(ro_en), .cnt_clr(cnt_clr),
    .cnt_gate(cnt_gate), .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy),
    .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] count;
    logic        drop;
    logic [1:0]  ro_en;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_data  = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_frame(input logic osc, input logic [15:0] cnt);
    exp_q.push_back({7'b1010000, osc});
    exp_q.push_back(cnt[15:8]);
    exp_q.push_back(cnt[7:0]);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check(nm, {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard: every handshake must match the next expected byte
  always @(negedge clk) begin
    if (reset_n && tx_valid && tx_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected actual=%h required=none", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          bad++;
          $display("FAIL tx_byte actual=%h required=%h", tx_data, mon_exp);
        end
      end
    end
  end

  initial begin
    int n, clr_n, gate_n, ro_bad;

    vt[0] = '{8'h01, 16'h1234, 1'b0, 2'b10};
    vt[1] = '{8'h00, 16'hBEEF, 1'b0, 2'b01};
    vt[2] = '{8'h55, 16'h0000, 1'b1, 2'b00};
    vt[3] = '{8'h00, 16'h0000, 1'b0, 2'b01};
    vt[4] = '{8'hFF, 16'h1111, 1'b1, 2'b00};
    vt[5] = '{8'h01, 16'hFFFF, 1'b0, 2'b10};
    vt[6] = '{8'h02, 16'h2222, 1'b1, 2'b00};

    reset_n = 1'b0; en = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
    ro_count = 16'h0000; tx_ready = 1'b1;
    #1;
    check("reset_outputs", {17'd0, ro_en, cnt_clr, cnt_gate, tx_valid, tx_data, busy, cmd_drop}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    en = 1'b1;
    tick();

    // Table: accepted commands are timed and framed, others must drop
    for (int i = 0; i < 7; i++) begin
      ro_count = vt[i].count;
      if (!vt[i].drop) push_frame(vt[i].cmd[0], vt[i].count);
      send_cmd(vt[i].cmd);
      check("cmd_drop", {31'd0, cmd_drop}, {31'd0, vt[i].drop});
      check("ro_en_start", {30'd0, ro_en}, {30'd0, vt[i].ro_en});
      if (vt[i].drop) begin
        check("drop_busy", {31'd0, busy}, 32'd0);
        tick();
        check("drop_pulse_end", {31'd0, cmd_drop}, 32'd0);
      end else begin
        n = 0; clr_n = 0; gate_n = 0; ro_bad = 0;
        while (busy && n < 200) begin
          n++;
          if (cnt_clr) clr_n++;
          if (cnt_gate) begin
            gate_n++;
            if (ro_en !== vt[i].ro_en) ro_bad++;
          end
          tick();
        end
        check("busy_len", n, 32'd25);
        check("clr_len", clr_n, 32'd1);
        check("gate_len", gate_n, 32'd16);
        check("ro_en_gate", ro_bad, 32'd0);
        check("frame_done", exp_q.size(), 32'd0);
      end
    end

    // Command arriving during SETTLE is dropped, measurement unaffected
    ro_count = 16'h5678;
    push_frame(1'b1, 16'h5678);
    send_cmd(8'h01);
    tick();
    send_cmd(8'h00);
    check("settle_drop", {31'd0, cmd_drop}, 32'd1);
    check("settle_ro_en", {30'd0, ro_en}, 32'd2);
    wait_idle("settle_idle");
    check("settle_frame", exp_q.size(), 32'd0);

    // Backpressure on the header byte
    tx_ready = 1'b0;
    ro_count = 16'h0A0B;
    push_frame(1'b0, 16'h0A0B);
    send_cmd(8'h00);
    n = 0;
    while (!tx_valid && n < 100) begin
      tick();
      n++;
    end
    check("bp_wait", {31'd0, tx_valid}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA0});
      tick();
    end
    tx_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_frame", exp_q.size(), 32'd0);

    // Abort by dropping en during GATE
    send_cmd(8'h00);
    n = 0;
    while (!cnt_gate && n < 50) begin
      tick();
      n++;
    end
    check("abort_gate_seen", {31'd0, cnt_gate}, 32'd1);
    tick(); tick();
    en = 1'b0;
    tick();
    check("abort_outputs", {28'd0, ro_en, cnt_gate, busy}, 32'd0);
    en = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (tx_valid) n++;
      tick();
    end
    check("abort_no_tx", n, 32'd0);

    // Asynchronous reset mid-GATE
    send_cmd(8'h01);
    n = 0;
    while (!cnt_gate && n < 50) begin
      tick();
      n++;
    end
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    check("async_reset", {17'd0, ro_en, cnt_clr, cnt_gate, tx_valid, tx_data, busy, cmd_drop}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    ro_count = 16'hC3A5;
    push_frame(1'b1, 16'hC3A5);
    send_cmd(8'h01);
    check("post_reset_accept", {29'd0, busy, ro_en}, {29'd0, 1'b1, 2'b10});
    wait_idle("post_reset_idle");
    check("post_reset_frame", exp_q.size(), 32'd0);

`ifdef ROSEQ_AUTO_EN
    // Idle timeout self-triggers, alternating RO0 then RO1
    ro_count = 16'h0102;
    push_frame(1'b0, 16'h0102);
    n = 0;
    while (!busy && n < 5000) begin
      tick();
      n++;
    end
    check("auto0_ro_en", {29'd0, busy, ro_en}, {29'd0, 1'b1, 2'b01});
    wait_idle("auto0_idle");
    ro_count = 16'h0304;
    push_frame(1'b1, 16'h0304);
    n = 0;
    while (!busy && n < 5000) begin
      tick();
      n++;
    end
    check("auto1_ro_en", {29'd0, busy, ro_en}, {29'd0, 1'b1, 2'b10});
    wait_idle("auto1_idle");
    check("auto_frames", exp_q.size(), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
